ifetch_sequencer: RTL and testbench
===================================

Name: ifetch_sequencer

Overview:
- Instruction-fetch controller that owns the program counter and drives the word-addressed instruction memory (byte addresses, bits [1:0] ignored).
- Issues at most one read per cycle and buffers returned words with their PCs in a small FIFO.
- Presents instructions to decode over a valid/ready handshake.
- Handles branch/jump redirects, flushing, and halt, so that decode stalls never lose or duplicate an instruction.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, instruction buffer entries (power of 2, 2..16).
- PTR_W, 2, log2(FIFO_DEPTH).

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- MemAddress  out  32  read address to instruction memory, registered.
- MemReq  out  1  read request, registered; data returns next cycle.
- MemInstruction  in  32  instruction memory data, valid the cycle after MemReq.
- Redirect  in  1  branch/jump taken; flush and restart.
- RedirectPC  in  32  restart address, sampled when Redirect=1.
- Halt  in  1  stop issuing new fetches (level).
- InstrValid  out  1  FIFO head valid.
- Instruction  out  32  FIFO head instruction.
- InstrPC  out  32  byte address of FIFO head.
- InstrReady  in  1  decode accepts head.
- Idle  out  1  HALTED state, FIFO empty, no read in flight.

Behaviour:
- Reset (async assert, sync deassert use):
  - PC=RESET_PC.
  - MemReq=0, MemAddress=RESET_PC.
  - FIFO empty, InstrValid=0, Instruction=0, InstrPC=0.
  - Pending flag=0, state=BOOT, Idle=0.
- FSM states:
  - BOOT: one cycle with no request, then RUN.
  - RUN → HALTED when Halt=1 and Redirect=0.
  - HALTED → RUN on Redirect=1, or when Halt=0.
  - Redirect is honoured in every state except BOOT. In BOOT, Redirect loads PC and the FSM still enters RUN.
- Issue rule (RUN only): issue when occupancy + pending < FIFO_DEPTH and Redirect=0.
  - On issue, next cycle MemReq=1, MemAddress=PC, PC=PC+4, pending=1.
  - Otherwise MemReq=0 next cycle.
  - PC wraps modulo 2^32.
- Response: in the cycle MemReq=1 and pending=1, push {MemAddress, MemInstruction} into the FIFO at the clock edge and clear pending, unless it is re-issued the same cycle.
- Credit rule guarantees no push into a full FIFO. Overflow is an assertion failure.
- Pop: InstrValid && InstrReady pops at the clock edge. Simultaneous push and pop keeps occupancy unchanged.
- Outputs: Instruction and InstrPC hold the FIFO head combinationally. When empty they are 0 and InstrValid=0.
- Redirect in cycle N:
  - FIFO cleared at the end of cycle N; any pop in N is ignored and flush wins.
  - A response arriving in N is discarded; pending=0.
  - MemReq=0 in N+1.
  - PC=RedirectPC with bits [1:0] forced to 00.
  - First new request is visible in N+2 with MemAddress = RedirectPC & ~3.
  - InstrValid=0 in N+1.
- Halt: a request already in flight still completes and pushes. Decode may keep draining the FIFO.
- Throughput: one instruction per cycle steady state when InstrReady=1.

Optional Feature:
- Macro: IFETCH_NOP_SQUASH_EN.
- When defined: responses equal to 32'h0000_0000 (nop) are not pushed into the FIFO. They still consume their issue slot and clear pending; the PC sequence is unchanged.
- When undefined: all words are pushed, including nops.

Test Plan:
1. Release reset with InstrReady=1 and memory words at 0x0,0x4,0x8 equal to 0x0000_0000, 0x2002_000E, 0x0000_0000 → MemReq first high 2 cycles after reset release; InstrValid stream gives PC 0x0, 0x4, 0x8 in consecutive cycles. With IFETCH_NOP_SQUASH_EN defined, only PC 0x4 is delivered.
2. InstrReady=0 for 10 cycles → exactly 4 entries buffered and MemReq low afterwards. Release ready → PCs delivered in order with no gap and no duplicate.
3. Redirect=1, RedirectPC=0x0000_0063 while the FIFO holds 3 entries and one read is in flight → InstrValid=0 next cycle; MemAddress=0x0000_0060 two cycles later; the stale response is never delivered.
4. Redirect and pop in the same cycle, with 1 entry → entry not counted as consumed; FIFO empty next cycle.
5. Halt=1 in RUN with one read in flight → in-flight word delivered, no new MemReq; Idle=1 once drained. Halt=0 → fetch resumes at the next sequential PC.
6. PC=0xFFFF_FFFC → next MemAddress 0x0000_0000. Assert Rst_n=0 mid-stream → all outputs return to reset values asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/ifetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues one memory read per cycle and
// buffers returned words for decode. Optional nop squashing via IFETCH_NOP_SQUASH_EN.
module ifetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          PTR_W      = 2
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  output logic [31:0] o_MemAddress,
  output logic        o_MemReq,
  input  logic [31:0] i_MemInstruction,
  input  logic        i_Redirect,
  input  logic [31:0] i_RedirectPC,
  input  logic        i_Halt,
  output logic        o_InstrValid,
  output logic [31:0] o_Instruction,
  output logic [31:0] o_InstrPC,
  input  logic        i_InstrReady,
  output logic        o_Idle
);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [31:0]      r_pc;
  logic [31:0]      r_memAddress;
  logic             r_memReq;
  logic             r_pending;
  logic [31:0]      r_fifoInstr [FIFO_DEPTH];
  logic [31:0]      r_fifoPC    [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W:0]   r_count;

  logic             w_respValid;
  logic             w_keep;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic [PTR_W+1:0] w_inUse;
  logic             w_issue;

  assign w_respValid = r_memReq && r_pending;

`ifdef IFETCH_NOP_SQUASH_EN
  assign w_keep = (i_MemInstruction != 32'h0000_0000);
`else
  assign w_keep = 1'b1;
`endif

  // Redirect wins over both the arriving response and any decode pop.
  assign w_push  = w_respValid && w_keep && !i_Redirect;
  assign w_pop   = o_InstrValid && i_InstrReady && !i_Redirect;
  assign w_full  = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_inUse = (PTR_W+2)'(r_count) + (PTR_W+2)'(r_pending);
  assign w_issue = (r_state == RUN) && !i_Halt && !i_Redirect &&
                   (w_inUse < (PTR_W+2)'(FIFO_DEPTH));

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      BOOT:    w_nextState = RUN;
      RUN:     if (i_Halt && !i_Redirect) w_nextState = HALTED;
      HALTED:  if (i_Redirect || !i_Halt) w_nextState = RUN;
      default: w_nextState = BOOT;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state      <= BOOT;
      r_pc         <= RESET_PC;
      r_memAddress <= RESET_PC;
      r_memReq     <= 1'b0;
      r_pending    <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_memReq <= w_issue;
      if (i_Redirect) begin
        r_pc <= {i_RedirectPC[31:2], 2'b00};
      end else if (w_issue) begin
        r_pc <= r_pc + 32'd4;
      end
      if (w_issue) begin
        r_memAddress <= r_pc;
      end
      if (w_issue) begin
        r_pending <= 1'b1;
      end else if (w_respValid || i_Redirect) begin
        r_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (i_Redirect) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: outputs are masked while the buffer is empty.
  always_ff @(posedge i_Clk) begin
    if (w_push) begin
      r_fifoInstr[r_wrPtr] <= i_MemInstruction;
      r_fifoPC[r_wrPtr]    <= r_memAddress;
    end
  end

  always_comb begin
    o_Instruction = '0;
    o_InstrPC     = '0;
    if (o_InstrValid) begin
      o_Instruction = r_fifoInstr[r_rdPtr];
      o_InstrPC     = r_fifoPC[r_rdPtr];
    end
  end

  assign o_InstrValid = (r_count != '0);
  assign o_MemReq     = r_memReq;
  assign o_MemAddress = r_memAddress;
  assign o_Idle       = (r_state == HALTED) && (r_count == '0) && !r_pending;

  // The issue credit must make a push into a full buffer impossible.
  assert property (@(posedge i_Clk) disable iff (!i_Rst_n) !(w_push && !w_pop && w_full));

endmodule

// File: tb/tb_ifetch_sequencer.sv
// Scoreboard testbench for ifetch_sequencer: a bench-side PC model predicts every
// fetch address and queues the words that decode should later receive.
module tb_ifetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock;
  logic        rstN;
  logic [31:0] memAddress;
  logic        memReq;
  logic [31:0] memInstruction;
  logic        redirect;
  logic [31:0] redirectPC;
  logic        halt;
  logic        instrValid;
  logic [31:0] instruction;
  logic [31:0] instrPC;
  logic        instrReady;
  logic        idle;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t      sb[$];
  logic [31:0] expFetchPc;
  int          checkCount;
  int          errorCount;

  ifetch_sequencer #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (4),
    .PTR_W      (2)
  ) dut (
    .i_Clk            (clock),
    .i_Rst_n          (rstN),
    .o_MemAddress     (memAddress),
    .o_MemReq         (memReq),
    .i_MemInstruction (memInstruction),
    .i_Redirect       (redirect),
    .i_RedirectPC     (redirectPC),
    .i_Halt           (halt),
    .o_InstrValid     (instrValid),
    .o_Instruction    (instruction),
    .o_InstrPC        (instrPC),
    .i_InstrReady     (instrReady),
    .o_Idle           (idle)
  );

  // Instruction memory image: nops at 0x0 and 0x8, a fixed word at 0x4, and an
  // address-derived non-zero pattern everywhere else.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0000_0000: memWord = 32'h0000_0000;
      32'h0000_0004: memWord = 32'h2002_000E;
      32'h0000_0008: memWord = 32'h0000_0000;
      default:       memWord = a ^ 32'h1357_9BDF;
    endcase
  endfunction

  function automatic logic keepWord(input logic [31:0] w);
`ifdef IFETCH_NOP_SQUASH_EN
    keepWord = (w != 32'h0000_0000);
`else
    keepWord = 1'b1;
`endif
  endfunction

  assign memInstruction = memWord(memAddress);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
    end
  endtask

  // Inputs change 1ns after the rising edge so they are stable for a whole cycle.
  task automatic applyStimulus(input logic redir, input logic [31:0] rpc, input logic hlt, input logic rdy);
    @(posedge clock);
    #1;
    redirect   = redir;
    redirectPC = rpc;
    halt       = hlt;
    instrReady = rdy;
  endtask

  // Lands just after the monitor has processed the current cycle.
  task automatic waitNeg();
    @(negedge clock);
    #1;
  endtask

  // Monitor: consumes deliveries from the scoreboard head and enqueues each
  // response that will land in the buffer at the coming edge.
  always @(negedge clock) begin
    if (!rstN) begin
      sb.delete();
      expFetchPc = RESET_PC;
    end else begin
      if (!redirect) begin
        checkOutput("instrValid", {31'b0, instrValid}, {31'b0, sb.size() != 0});
        if (instrValid && instrReady && sb.size() != 0) begin
          entry_t e;
          e = sb.pop_front();
          checkOutput("instrPC", instrPC, e.pc);
          checkOutput("instruction", instruction, e.word);
        end
      end
      if (memReq) begin
        checkOutput("memAddress", memAddress, expFetchPc);
        if (!redirect && keepWord(memWord(expFetchPc))) begin
          sb.push_back('{pc: expFetchPc, word: memWord(expFetchPc)});
        end
        expFetchPc = expFetchPc + 32'd4;
      end
      if (redirect) begin
        sb.delete();
        expFetchPc = {redirectPC[31:2], 2'b00};
      end
    end
  end

  initial begin
    logic        found;
    logic [31:0] resumePc;
    checkCount = 0;
    errorCount = 0;
    expFetchPc = RESET_PC;
    rstN       = 1'b0;
    redirect   = 1'b0;
    redirectPC = 32'h0;
    halt       = 1'b0;
    instrReady = 1'b1;
    #2;
    checkOutput("rst_memReq", {31'b0, memReq}, 32'd0);
    checkOutput("rst_memAddress", memAddress, RESET_PC);
    checkOutput("rst_instrValid", {31'b0, instrValid}, 32'd0);
    checkOutput("rst_instruction", instruction, 32'd0);
    checkOutput("rst_instrPC", instrPC, 32'd0);
    checkOutput("rst_idle", {31'b0, idle}, 32'd0);

    // Boot timing and the first three words.
    repeat (2) @(posedge clock);
    #1 rstN = 1'b1;
    waitNeg();
    checkOutput("boot_memReq0", {31'b0, memReq}, 32'd0);
    waitNeg();
    checkOutput("boot_memReq1", {31'b0, memReq}, 32'd0);
    waitNeg();
    checkOutput("boot_memReq2", {31'b0, memReq}, 32'd1);
    checkOutput("boot_addr", memAddress, 32'h0);
`ifdef IFETCH_NOP_SQUASH_EN
    waitNeg();
    checkOutput("t1_nopSquashed", {31'b0, instrValid}, 32'd0);
    waitNeg();
    checkOutput("t1_valid4", {31'b0, instrValid}, 32'd1);
    checkOutput("t1_pc4", instrPC, 32'h4);
`else
    for (int i = 0; i < 3; i++) begin
      waitNeg();
      checkOutput("t1_valid", {31'b0, instrValid}, 32'd1);
      checkOutput("t1_pc", instrPC, 32'(4 * i));
    end
`endif

    // Decode stall: buffer fills to depth, then drains without gaps.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (10) waitNeg();
    checkOutput("t2_memReqLow", {31'b0, memReq}, 32'd0);
    checkOutput("t2_buffered", 32'(sb.size()), 32'd4);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      waitNeg();
      checkOutput("t2_noGap", {31'b0, instrValid}, 32'd1);
    end

    // Redirect with three buffered entries and one read in flight.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      waitNeg();
      if (sb.size() == 3 && memReq) found = 1'b1;
    end
    checkOutput("t3_setup", {31'b0, found}, 32'd1);
    applyStimulus(1'b1, 32'h0000_0063, 1'b0, 1'b0);
    waitNeg();
    checkOutput("t3_inflight", {31'b0, memReq}, 32'd1);
    checkOutput("t3_buffered", {31'b0, instrValid}, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    waitNeg();
    checkOutput("t3_validDrop", {31'b0, instrValid}, 32'd0);
    checkOutput("t3_noReq", {31'b0, memReq}, 32'd0);
    waitNeg();
    checkOutput("t3_newReq", {31'b0, memReq}, 32'd1);
    checkOutput("t3_newAddr", memAddress, 32'h0000_0060);

    // Redirect and pop in the same cycle with one entry buffered.
    applyStimulus(1'b1, 32'h0000_0200, 1'b0, 1'b1);
    waitNeg();
    checkOutput("t4_oneEntry", {31'b0, instrValid}, 32'd1);
    checkOutput("t4_headPc", instrPC, 32'h0000_0060);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    waitNeg();
    checkOutput("t4_flushed", {31'b0, instrValid}, 32'd0);
    waitNeg();
    checkOutput("t4_newAddr", memAddress, 32'h0000_0200);
    repeat (4) waitNeg();

    // Halt with a read in flight, drain to idle, then resume.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    waitNeg();
    checkOutput("t5_inflight", {31'b0, memReq}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      waitNeg();
      checkOutput("t5_noReq", {31'b0, memReq}, 32'd0);
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (idle) found = 1'b1;
      else waitNeg();
    end
    checkOutput("t5_idle", {31'b0, idle}, 32'd1);
    checkOutput("t5_drained", 32'(sb.size()), 32'd0);
    resumePc = expFetchPc;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clock);
      if (memReq) found = 1'b1;
    end
    checkOutput("t5_resumeReq", {31'b0, memReq}, 32'd1);
    checkOutput("t5_resumeAddr", memAddress, resumePc);
    repeat (4) waitNeg();

    // PC wrap, then asynchronous reset in the middle of a cycle.
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    waitNeg();
    waitNeg();
    checkOutput("t6_topAddr", memAddress, 32'hFFFF_FFFC);
    waitNeg();
    checkOutput("t6_wrapReq", {31'b0, memReq}, 32'd1);
    checkOutput("t6_wrapAddr", memAddress, 32'h0000_0000);
    repeat (2) waitNeg();
    @(posedge clock);
    #3 rstN = 1'b0;
    #1;
    checkOutput("t6_rstMemReq", {31'b0, memReq}, 32'd0);
    checkOutput("t6_rstAddr", memAddress, RESET_PC);
    checkOutput("t6_rstValid", {31'b0, instrValid}, 32'd0);
    checkOutput("t6_rstInstr", instruction, 32'd0);
    checkOutput("t6_rstPC", instrPC, 32'd0);
    checkOutput("t6_rstIdle", {31'b0, idle}, 32'd0);
    repeat (2) @(posedge clock);
    #1 rstN = 1'b1;
    repeat (8) waitNeg();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
